// File: rtl/rr_hold_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_hold_arbiter_if
//
// Request/grant bundle between N requesters and the round-robin arbiter
// that owns one shared resource. Vectors are indexed [0:N-1], so in a bit
// literal the leftmost bit is requester 0.
//
// Signals:
//   r        [0:N-1]   level-held request vector (requester side drives)
//   g        [0:N-1]   registered one-hot grant, all zero when idle
//   grant_id [IDW-1:0] index of the current owner, 0 when idle
//   busy               high while any g bit is high
//   preempt            one-cycle pulse when tenure expiry moves the grant
//                      away from an owner that is still requesting
//
// Modports:
//   master  requester side: drives r, observes the grant outputs
//   slave   arbiter side:   observes r, drives the grant outputs
// ---------------------------------------------------------------------------
interface rr_hold_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);

  logic [0:N-1]   r;
  logic [0:N-1]   g;
  logic [IDW-1:0] grant_id;
  logic           busy;
  logic           preempt;

  modport master (
    output r,
    input  g,
    input  grant_id,
    input  busy,
    input  preempt
  );

  modport slave (
    input  r,
    output g,
    output grant_id,
    output busy,
    output preempt
  );

endinterface

// File: rtl/rr_hold_arbiter.sv
// ---------------------------------------------------------------------------
// rr_hold_arbiter
//
// Clocked round-robin arbiter for N requesters sharing one resource.
// Priority rotates so no requester starves: the search for a winner starts
// at ptr and wraps modulo N, and every new grant moves ptr just past the
// winner. An owner keeps the grant while it keeps requesting, bounded by a
// tenure of MAX_HOLD cycles whenever somebody else is waiting
// (MAX_HOLD = 0 means unlimited tenure). All outputs are registered so the
// one-hot grant can drive the resource mux directly.
//
// Parameters:
//   N         number of requesters (N >= 2)
//   MAX_HOLD  tenure limit in cycles while others wait; 0 = unlimited
//   IDW       width of grant_id, equal to ceil(log2(N))
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    rr_hold_arbiter_if.slave: r in; g, grant_id, busy, preempt out
// ---------------------------------------------------------------------------
module rr_hold_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDW      = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_hold_arbiter_if.slave     bus
);

  // Tenure counter only needs to reach MAX_HOLD; keep at least one bit so
  // the unlimited configuration still elaborates.
  localparam int             CW       = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0]  HOLD_LIM = CW'(MAX_HOLD);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [IDW:0]   N_W      = (IDW + 1)'(N);
  localparam logic [IDW-1:0] LAST     = IDW'(N - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [CW-1:0]  cnt;

  // -------------------------------------------------------------------------
  // Winner search
  // -------------------------------------------------------------------------
  // Masking the current owner out of the candidates covers every case with a
  // single search: in IDLE g is zero so nothing is masked; on a release the
  // owner's request is already low; on tenure expiry the owner must be
  // skipped. If the owner is the only requester, found stays low and the
  // owner simply keeps the grant.
  logic [0:N-1]   cand;
  logic           found;
  logic [IDW-1:0] win;
  logic [IDW:0]   idx;
  logic [0:N-1]   win_oh;
  logic [IDW-1:0] nxt_ptr;
  logic           own_req;
  logic           expire;
  logic           take;

  assign cand = bus.r & ~bus.g;

  // NOTE: every signal driven here gets a default at the top of the block;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      // ptr + k stays below 2N, so one conditional subtract is the modulo.
      idx = {1'b0, ptr} + (IDW + 1)'(k);
      if (idx >= N_W) begin
        idx = idx - N_W;
      end
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    win_oh      = '0;
    win_oh[win] = 1'b1;
  end

  assign nxt_ptr = (win == LAST) ? '0 : win + 1'b1;

  // The owner is still requesting iff its grant bit overlaps its request.
  assign own_req = |(bus.r & bus.g);

  assign expire  = (MAX_HOLD != 0) && (cnt == HOLD_LIM);

  // A new grant is issued from IDLE on any request, on a release when
  // somebody else is waiting, or on expiry when somebody else is waiting.
  assign take = found && ((state == IDLE) || !own_req || expire);

  // -------------------------------------------------------------------------
  // State machine and registered outputs
  // -------------------------------------------------------------------------
  // NOTE: state and outputs use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: all of these are control registers, so every one is reset; there
  // is no storage array here that could be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      cnt          <= '0;
      bus.g        <= '0;
      bus.grant_id <= '0;
      bus.busy     <= 1'b0;
      bus.preempt  <= 1'b0;
    end else begin
      bus.preempt <= 1'b0;

      case (state)
        IDLE: begin
          if (take) begin
            state        <= GRANT;
            bus.g        <= win_oh;
            bus.grant_id <= win;
            bus.busy     <= 1'b1;
            ptr          <= nxt_ptr;
            cnt          <= CNT_ONE;
          end
        end

        GRANT: begin
          if (take) begin
            // Hand-over on release or expiry happens at this same edge, so
            // the resource never sees a dead cycle between owners.
            bus.g        <= win_oh;
            bus.grant_id <= win;
            ptr          <= nxt_ptr;
            cnt          <= CNT_ONE;
            // Only an expiry takes the grant from an owner still asking.
            bus.preempt  <= own_req;
          end else if (!own_req) begin
            // Released with nobody else waiting.
            state        <= IDLE;
            bus.g        <= '0;
            bus.grant_id <= '0;
            bus.busy     <= 1'b0;
          end else if (expire) begin
            // Sole requester at the limit: start a fresh tenure, ptr kept.
            cnt <= CNT_ONE;
          end else if (MAX_HOLD != 0) begin
            // Not expired implies cnt < MAX_HOLD, so this cannot overflow.
            cnt <= cnt + CNT_ONE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
